// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I op classes, opcodes and instruction formats
package rv32i_pkg;

  // Request op_class codes
  localparam logic [3:0] CLS_ALU    = 4'd0;
  localparam logic [3:0] CLS_ALU_I  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LUI    = 4'd5;
  localparam logic [3:0] CLS_AUIPC  = 4'd6;
  localparam logic [3:0] CLS_JAL    = 4'd7;
  localparam logic [3:0] CLS_JALR   = 4'd8;

  // Major opcodes, shared with the core's decoder
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

endpackage

// File: rtl/rv32i_encoder_instr_fifo.sv
// rtl/rv32i_encoder_instr_fifo.sv - first-word-fall-through instruction FIFO with occupancy count
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && (r_count != CW'(DEPTH));
  assign w_pop  = pop && (r_count != '0);
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rv32i_encoder.sv
// rtl/rv32i_encoder.sv - packs instruction class and fields into RV32I words, buffered by a FIFO
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_class,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] emit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  fmt_e             w_fmt;
  logic [6:0]       w_opc;
  logic             w_legal;
  logic [31:0]      w_word;
  logic             w_shift;
  logic             w_i_ok;
  logic             w_b_ok;
  logic             w_j_ok;
  logic [6:0]       w_i_hi;
  logic             w_accept;
  logic             w_pop;
  logic [31:0]      w_head;
  logic [CW-1:0]    w_count;
  logic [31:0]      r_last;
  logic             r_err;
  logic [CNT_W-1:0] r_emit_cnt;

  assign w_shift = (op_class == CLS_ALU_I) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  assign w_i_ok  = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign w_b_ok  = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign w_j_ok  = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
  assign w_i_hi  = w_shift ? funct7 : imm[11:5];

  // Classify the request: format, opcode and immediate range legality
  always_comb begin
    w_fmt   = FMT_R;
    w_opc   = 7'd0;
    w_legal = 1'b0;
    case (op_class)
      CLS_ALU:    begin w_fmt = FMT_R; w_opc = OPC_OP;     w_legal = 1'b1; end
      CLS_ALU_I:  begin w_fmt = FMT_I; w_opc = OPC_OP_IMM; w_legal = w_shift ? (imm[31:5] == '0) : w_i_ok; end
      CLS_LOAD:   begin w_fmt = FMT_I; w_opc = OPC_LOAD;   w_legal = w_i_ok; end
      CLS_STORE:  begin w_fmt = FMT_S; w_opc = OPC_STORE;  w_legal = w_i_ok; end
      CLS_BRANCH: begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_legal = w_b_ok; end
      CLS_LUI:    begin w_fmt = FMT_U; w_opc = OPC_LUI;    w_legal = (imm[11:0] == '0); end
      CLS_AUIPC:  begin w_fmt = FMT_U; w_opc = OPC_AUIPC;  w_legal = (imm[11:0] == '0); end
      CLS_JAL:    begin w_fmt = FMT_J; w_opc = OPC_JAL;    w_legal = w_j_ok; end
      CLS_JALR:   begin w_fmt = FMT_I; w_opc = OPC_JALR;   w_legal = w_i_ok; end
      default:    begin w_fmt = FMT_R; w_opc = 7'd0;       w_legal = 1'b0; end
    endcase
  end

  // Scatter fields into the standard bit layout for the chosen format
  always_comb begin
    w_word = 32'd0;
    case (w_fmt)
      FMT_R:   w_word = {funct7, rs2, rs1, funct3, rd, w_opc};
      FMT_I:   w_word = {w_i_hi, imm[4:0], rs1, funct3, rd, w_opc};
      FMT_S:   w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], w_opc};
      FMT_B:   w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], w_opc};
      FMT_U:   w_word = {imm[31:12], rd, w_opc};
      FMT_J:   w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, w_opc};
      default: w_word = 32'd0;
    endcase
  end

  assign in_ready  = (w_count < CW'(DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_instr = out_valid ? w_head : r_last;
  assign err       = r_err;
  assign emit_cnt  = r_emit_cnt;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept && w_legal),
    .din   (w_word),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  // Sticky error, popped-word counter and last-popped word held while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_emit_cnt <= '0;
      r_last     <= 32'd0;
    end else begin
      if (w_accept && !w_legal) r_err <= 1'b1;
      else if (err_clr)         r_err <= 1'b0;
      if (w_pop) begin
        r_emit_cnt <= r_emit_cnt + 1'b1;
        r_last     <= w_head;
      end
    end
  end

endmodule
